// File: rtl/uart_rx_param_pkg.sv
// Shared UART receive definitions: FSM state encoding, legal parameter
// ranges and the parity helper used by the receiver and its checker.
package uart_rx_param_pkg;

  localparam int CLKS_PER_BIT_MIN = 4;
  localparam int CLKS_PER_BIT_MAX = 65535;
  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_states_t;

  // Expected parity bit for a word; zero padding above the data does not
  // change the XOR, so narrower words are simply zero-extended.
  function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] word,
                                     input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_param_chk.sv
// Elaboration-time guard: refuses to build the receiver with parameter
// values outside the supported ranges.
module uart_rx_param_chk
  import uart_rx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
);

  generate
    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX) begin : g_bad_clks
      $error("uart_rx_param: CLKS_PER_BIT out of range");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
      $error("uart_rx_param: DATA_BITS out of range");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_par_en
      $error("uart_rx_param: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par_odd
      $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

endmodule

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs. Resets to all ones so an
// idle-high serial line never looks like a start bit out of reset.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Capture the raw input and re-register it to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b1}};
      q      <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver with mid-bit sampling, start-bit
// glitch rejection, optional parity, 1/2 stop bits and a ready/valid
// output carrying parity/frame error flags and a sticky overrun.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_CNT   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_CNT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);

  uart_rx_param_chk #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY_EN    (PARITY_EN),
    .PARITY_ODD   (PARITY_ODD),
    .STOP_BITS    (STOP_BITS)
  ) u_chk ();

  logic                 rx_s;
  rx_states_t           state_r, state_next_s;
  logic [TW-1:0]        timer_r, timer_next_s;
  logic [IW-1:0]        idx_r, idx_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 par_err_r, par_err_next_s;
  logic                 frm_err_r, frm_err_next_s;
  logic                 deliver_s;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxIn),
    .q   (rx_s)
  );

  // Frame state machine: registered state, counters and receive latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      timer_r   <= {TW{1'b0}};
      idx_r     <= {IW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      timer_r   <= timer_next_s;
      idx_r     <= idx_next_s;
      shift_r   <= shift_next_s;
      par_err_r <= par_err_next_s;
      frm_err_r <= frm_err_next_s;
    end
  end

  // Next-state logic: start-bit qualification at mid-bit, then one sample
  // per bit period; the last stop sample raises the delivery event.
  always_comb begin
    state_next_s   = state_r;
    timer_next_s   = timer_r + TW'(1);
    idx_next_s     = idx_r;
    shift_next_s   = shift_r;
    par_err_next_s = par_err_r;
    frm_err_next_s = frm_err_r;
    deliver_s      = 1'b0;
    case (state_r)
      IDLE: begin
        timer_next_s = {TW{1'b0}};
        if (!rx_s) begin
          state_next_s   = START;
          idx_next_s     = {IW{1'b0}};
          par_err_next_s = 1'b0;
          frm_err_next_s = 1'b0;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (timer_r == MID_CNT) begin
          timer_next_s = {TW{1'b0}};
          if (rx_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (timer_r == FULL_CNT) begin
          timer_next_s = {TW{1'b0}};
          shift_next_s = {rx_s, shift_r[DATA_BITS-1:1]};
          if (idx_r == LAST_DATA) begin
            idx_next_s = {IW{1'b0}};
            if (PARITY_EN != 0) begin
              state_next_s = PARITY;
            end else begin
              state_next_s = STOP;
            end
          end else begin
            idx_next_s = idx_r + IW'(1);
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (timer_r == FULL_CNT) begin
          timer_next_s   = {TW{1'b0}};
          par_err_next_s = (parity_of(DATA_BITS_MAX'(shift_r), ODD_PAR) != rx_s);
          state_next_s   = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (timer_r == FULL_CNT) begin
          timer_next_s   = {TW{1'b0}};
          frm_err_next_s = frm_err_r | ~rx_s;
          if (idx_r == LAST_STOP) begin
            idx_next_s = {IW{1'b0}};
            deliver_s  = 1'b1;
            if (frm_err_next_s && !rx_s) begin
              state_next_s = BREAK;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            idx_next_s = idx_r + IW'(1);
          end
        end else begin
          state_next_s = STOP;
        end
      end
      BREAK: begin
        timer_next_s = {TW{1'b0}};
        if (rx_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BREAK;
        end
      end
      default: begin
        state_next_s = IDLE;
        timer_next_s = {TW{1'b0}};
      end
    endcase
  end

  // Output register: load a finished word when the slot is free or being
  // emptied this cycle, otherwise drop it and flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut   <= {DATA_BITS{1'b0}};
      valid     <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (deliver_s && (!valid || ready)) begin
        dataOut   <= shift_r;
        parityErr <= par_err_r;
        frameErr  <= frm_err_next_s;
        valid     <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end
      if (deliver_s && valid && !ready) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
      busy <= (state_next_s != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: four instances cover 8N1, 8E1, 8N2
// and 9N1; expected words are queued at stimulus time and checked by a
// monitor on every handshake.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk, rst, rst_w;
  logic rx_a, rx_p, rx_b, rx_w;
  logic ready_a, ready_p, ready_b, ready_w;
  logic [7:0] dout_a, dout_p, dout_b;
  logic [8:0] dout_w;
  logic valid_a, valid_p, valid_b, valid_w;
  logic perr_a, perr_p, perr_b, perr_w;
  logic ferr_a, ferr_p, ferr_b, ferr_w;
  logic ovr_a, ovr_p, ovr_b, ovr_w;
  logic busy_a, busy_p, busy_b, busy_w;

  exp_t q_a[$];
  exp_t q_p[$];
  exp_t q_b[$];
  exp_t q_w[$];

  int checks = 0;
  int errors = 0;
  int lat;

  uart_rx_param #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst), .rxIn(rx_a), .dataOut(dout_a), .valid(valid_a),
    .ready(ready_a), .parityErr(perr_a), .frameErr(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .rxIn(rx_p), .dataOut(dout_p), .valid(valid_p),
    .ready(ready_p), .parityErr(perr_p), .frameErr(ferr_p), .overrun(ovr_p), .busy(busy_p));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rxIn(rx_b), .dataOut(dout_b), .valid(valid_b),
    .ready(ready_b), .parityErr(perr_b), .frameErr(ferr_b), .overrun(ovr_b), .busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9)) dut_w (
    .clk(clk), .rst(rst_w), .rxIn(rx_w), .dataOut(dout_w), .valid(valid_w),
    .ready(ready_w), .parityErr(perr_w), .frameErr(ferr_w), .overrun(ovr_w), .busy(busy_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input int inst, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    logic have;
    have = 1'b0;
    e = '0;
    case (inst)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      1: if (q_p.size() > 0) begin e = q_p.pop_front(); have = 1'b1; end
      2: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      default: if (q_w.size() > 0) begin e = q_w.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL word%0d unexpected word data=%h perr=%b ferr=%b", inst, d, pe, fe);
    end else if ({d, pe, fe} !== {e.data, e.perr, e.ferr}) begin
      errors++;
      $display("FAIL word%0d got data=%h perr=%b ferr=%b expected data=%h perr=%b ferr=%b",
               inst, d, pe, fe, e.data, e.perr, e.ferr);
    end
  endtask

  // Monitor: every accepted word is compared against the scoreboard.
  always @(negedge clk) begin
    if (valid_a && ready_a) sb_pop(0, {1'b0, dout_a}, perr_a, ferr_a);
    if (valid_p && ready_p) sb_pop(1, {1'b0, dout_p}, perr_p, ferr_p);
    if (valid_b && ready_b) sb_pop(2, {1'b0, dout_b}, perr_b, ferr_b);
    if (valid_w && ready_w) sb_pop(3, dout_w, perr_w, ferr_w);
  end

  task automatic drive_line(input int inst, input logic v);
    case (inst)
      0: rx_a = v;
      1: rx_p = v;
      2: rx_b = v;
      default: rx_w = v;
    endcase
  endtask

  // Drives nbits LSB-first, one bit period each; call at posedge+1.
  task automatic send_bits(input int inst, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive_line(inst, bits[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1; rx_w = 1'b1;
    ready_a = 1'b1; ready_p = 1'b1; ready_b = 1'b1; ready_w = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0; rst_w = 1'b0;
    @(negedge clk);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_overrun_a", 32'(ovr_a), 32'd0);
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_flags_a", 32'({perr_a, ferr_a}), 32'd0);
    check("rst_valid_w", 32'(valid_w), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);

    // 8N1 0xA5 with latency measured from the rxIn start edge (+2 sync).
    repeat (4) @(posedge clk);
    #1;
    q_a.push_back({9'h0A5, 1'b0, 1'b0});
    fork
      send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
      begin
        lat = 0;
        while (!valid_a && lat < 400) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
      end
    join
    check("latency_a", 32'(lat), 32'd155);
    repeat (20) @(posedge clk);
    #1;

    // Start-bit glitch: 5 cycles low must be rejected.
    drive_line(0, 1'b0);
    repeat (5) @(posedge clk);
    #1 drive_line(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("glitch_busy_high", 32'(busy_a), 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_low", 32'(busy_a), 32'd0);
    repeat (100) @(posedge clk);
    #1;

    // Even parity: 0x03 with bad then good parity bit.
    q_p.push_back({9'h003, 1'b1, 1'b0});
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    q_p.push_back({9'h003, 1'b0, 1'b0});
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    repeat (20) @(posedge clk);
    #1;

    // Two stop bits, second low, then the line held low (break).
    q_b.push_back({9'h05A, 1'b0, 1'b1});
    send_bits(2, {5'b0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("break_busy", 32'(busy_b), 32'd1);
    check("break_valid_low", 32'(valid_b), 32'd0);
    @(posedge clk);
    #1 drive_line(2, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("break_exit_busy", 32'(busy_b), 32'd0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("break_no_spurious", 32'(valid_b), 32'd0);
    check("break_overrun", 32'(ovr_b), 32'd0);
    @(posedge clk);
    #1;

    // Overrun: ready low, two back-to-back frames; second is dropped.
    ready_a = 1'b0;
    q_a.push_back({9'h011, 1'b0, 1'b0});
    send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ovr_valid_held", 32'(valid_a), 32'd1);
    check("ovr_dout_held", 32'(dout_a), 32'h11);
    check("ovr_set", 32'(ovr_a), 32'd1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_valid_drop", 32'(valid_a), 32'd0);
    @(posedge clk);
    #1;
    q_a.push_back({9'h033, 1'b0, 1'b0});
    send_bits(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ovr_sticky", 32'(ovr_a), 32'd1);
    @(posedge clk);
    #1;

    // 9-bit: hold a word, reset mid-frame, then receive 0x155.
    ready_w = 1'b0;
    send_bits(3, {5'b0, 1'b1, 9'h0AA, 1'b0}, 11);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("w_held_valid", 32'(valid_w), 32'd1);
    check("w_held_dout", 32'(dout_w), 32'h0AA);
    @(posedge clk);
    #1;
    send_bits(3, {10'b0, 5'h1F, 1'b0}, 6);
    check("w_busy_mid", 32'(busy_w), 32'd1);
    rst_w = 1'b1;
    #2;
    check("w_rst_valid", 32'(valid_w), 32'd0);
    check("w_rst_dout", 32'(dout_w), 32'd0);
    check("w_rst_busy", 32'(busy_w), 32'd0);
    check("w_rst_flags", 32'({perr_w, ferr_w, ovr_w}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_w = 1'b0;
    ready_w = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    q_w.push_back({9'h155, 1'b0, 1'b0});
    send_bits(3, {5'b0, 1'b1, 9'h155, 1'b0}, 11);
    repeat (20) @(posedge clk);
    @(negedge clk);

    check("q_a_empty", 32'(q_a.size()), 32'd0);
    check("q_p_empty", 32'(q_p.size()), 32'd0);
    check("q_b_empty", 32'(q_b.size()), 32'd0);
    check("q_w_empty", 32'(q_w.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampled UART receiver. It is the next generation of the team's single-rate byte receiver. It adds:
- a configurable data width, parity and stop-bit count
- mid-bit sampling with start-bit glitch rejection
- a ready/valid output with error flags
It sits between the pad-side serial input and the byte-stream consumer (FIFO or register bank), alongside the existing transmitter.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 = a parity bit follows the data.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity. Ignored when PARITY_EN=0.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
rxIn  in  1  raw serial line; idle high; asynchronous to clk.
dataOut  out  DATA_BITS  received word, LSB = first data bit.
valid  out  1  dataOut and the error flags are valid.
ready  in  1  consumer accepts the word when valid && ready.
parityErr  out  1  parity mismatch for the current word; qualified by valid.
frameErr  out  1  a stop bit was sampled low for the current word; qualified by valid.
overrun  out  1  sticky; a frame completed while valid && !ready.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync-released flops):
  - outputs: dataOut=0, valid=0, parityErr=0, frameErr=0, overrun=0, busy=0
  - internal: FSM=IDLE, counters=0, synchroniser flops=1
  - reset mid-frame aborts the frame; nothing is delivered.
- Input path: rxIn passes through a 2-flop synchroniser; rxS is the synchronised line. All timing below is relative to rxS.
- Counters:
  - bitTimer: $clog2(CLKS_PER_BIT) bits.
  - bitIdx: $clog2(DATA_BITS) bits.
  - Mid-bit point is bitTimer == CLKS_PER_BIT/2 - 1, counted from the falling edge for the start bit. Each subsequent bit is sampled CLKS_PER_BIT cycles after the previous sample.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rxS==0 -> START, bitTimer cleared.
  - START: at mid-bit, rxS==1 -> IDLE (glitch, no output); rxS==0 -> DATA.
  - DATA: one sample per bit period, shifted in LSB-first. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample bit p. The error is (^data ^ p) != PARITY_ODD. Then -> STOP.
  - STOP: sample each of the STOP_BITS stop bits; any low sample sets the frame-error latch. After the last stop sample:
    - delivery event (below)
    - if the frame error is set and rxS==0 -> BREAK
    - otherwise -> IDLE
- BREAK: wait for rxS==1, then -> IDLE. No new start is detected until the line returns high.
- Delivery event, registered, valid rises the cycle after the last stop sample:
  - if valid==0, or valid && ready that same cycle: load dataOut, parityErr and frameErr, and set valid=1.
  - else: the new word is dropped, the old word is kept, and overrun is set to 1.
- Handshake:
  - valid stays high until a cycle with ready=1; it falls the next cycle unless a delivery event loads a new word in that same cycle.
  - dataOut and the flags are stable while valid && !ready.
- overrun is cleared only by rst.
- The next start bit may begin on the cycle after the last stop sample. This gives back-to-back frames with no dead time.
- The parity bit is never exposed on dataOut.

Decomposition:
- Shared uartUtil package:
  - enum rx_states_t {IDLE, START, DATA, PARITY, STOP, BREAK}
  - function parityOf(word, odd)
  - constants for the legal parameter ranges
- Elaboration-time assertions reject illegal parameter values.
- One natural sub-module: uart_rx_sync, a 2-flop synchroniser with a reset value of 1 and a WIDTH parameter. The transmitter reuses it for its cts input.

Test Plan:
1. 8N1, CLKS_PER_BIT=16, send 0xA5, ready=1 -> one valid pulse, dataOut=0xA5, parityErr=0, frameErr=0. valid rises 16*9+8+1 cycles after the rxS falling edge.
2. rxIn low for 5 cycles then high, CLKS_PER_BIT=16 -> FSM returns to IDLE, valid never asserts, busy falls by cycle 8.
3. PARITY_EN=1, even parity, send 0x03 with parity bit=1 -> dataOut=0x03, parityErr=1. Resend with parity bit=0 -> parityErr=0.
4. STOP_BITS=2, second stop bit driven low, then line held low 40 cycles -> frameErr=1 with valid; FSM in BREAK until rxIn returns high; no spurious frame.
5. ready=0, send 0x11 then 0x22 back-to-back -> dataOut stays 0x11, overrun=1. ready=1 -> valid drops after one handshake; a third frame 0x33 is delivered normally; overrun stays 1.
6. DATA_BITS=9, assert rst mid-way through DATA of 0x1FF -> all outputs 0 immediately (async). After release, send 0x155 -> dataOut=0x155.
